// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage: latches a request, runs the RAM for
// WAIT_STATES+1 cycles and pulses Ready. Define DMEM_BUS_ERROR_EN to report out-of-window hits on BusErr.
module dmem_access_ctrl #(
   parameter int          DATA_W      = 32,
   parameter logic [31:0] MEM_BASE    = 32'h0500,
   parameter int          MEM_AW      = 10,
   parameter int          WAIT_STATES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       Address,
   input  logic              CS,
   input  logic              Req,
   input  logic              WE,
   input  logic [DATA_W-1:0] WData,
   input  logic [DATA_W-1:0] MemRData,
   output logic              MemEN,
   output logic              MemWE,
   output logic [MEM_AW-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   output logic [DATA_W-1:0] RData,
   output logic              Ready,
   output logic              Stall,
   output logic              BusErr
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   state_t            state;
   logic [3:0]        cnt;
   logic [MEM_AW-1:0] offset;
   logic              unused_addr_hi;

   // Only the low MEM_AW bits matter: the offset wraps modulo the window size.
   assign offset         = Address[MEM_AW-1:0] - MEM_BASE[MEM_AW-1:0];
   assign unused_addr_hi = ^Address[31:MEM_AW];

   assign Stall = ((state == IDLE) && Req) || (state == ACCESS);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         MemEN    <= 1'b0;
         MemWE    <= 1'b0;
         Ready    <= 1'b0;
         RData    <= '0;
         MemAddr  <= '0;
         MemWData <= '0;
      end else begin
         case (state)
            IDLE: begin
               Ready <= 1'b0;
               if (Req) begin
                  if (CS) begin
                     MemAddr  <= offset;
                     MemWData <= WData;
                     MemWE    <= WE;
                     MemEN    <= 1'b1;
                     cnt      <= WAIT_INIT;
                     state    <= ACCESS;
                  end else begin
                     Ready <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // MemWE still holds the latched direction on this last cycle.
                  if (!MemWE) RData <= MemRData;
                  MemEN <= 1'b0;
                  MemWE <= 1'b0;
                  Ready <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               Ready <= 1'b0;
               state <= IDLE;
            end
            default: begin
               MemEN <= 1'b0;
               MemWE <= 1'b0;
               Ready <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DMEM_BUS_ERROR_EN
   logic bus_err;

   // High exactly in the DONE cycle that follows an out-of-window request.
   always_ff @(posedge CLK) begin
      if (RST) bus_err <= 1'b0;
      else     bus_err <= (state == IDLE) && Req && !CS;
   end

   assign BusErr = bus_err;
`else
   assign BusErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: one instance with 2 wait states, one with none,
// each backed by a small word RAM model.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        cs = 1'b0;
   logic        req = 1'b0;
   logic        req0 = 1'b0;
   logic        we = 1'b0;
   logic [31:0] wdata = '0;

   logic        men, mwe, rdy, stall, berr;
   logic [9:0]  maddr;
   logic [31:0] mwdata, rdata, mrdata;
   logic        men0, mwe0, rdy0, stall0, berr0;
   logic [9:0]  maddr0;
   logic [31:0] mwdata0, rdata0, mrdata0;

   logic [31:0] mem  [0:255];
   logic [31:0] mem0 [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.WAIT_STATES(2)) dut (
      .CLK(clk), .RST(rst), .Address(addr), .CS(cs), .Req(req), .WE(we), .WData(wdata),
      .MemRData(mrdata), .MemEN(men), .MemWE(mwe), .MemAddr(maddr), .MemWData(mwdata),
      .RData(rdata), .Ready(rdy), .Stall(stall), .BusErr(berr)
   );

   dmem_access_ctrl #(.WAIT_STATES(0)) dut0 (
      .CLK(clk), .RST(rst), .Address(addr), .CS(cs), .Req(req0), .WE(we), .WData(wdata),
      .MemRData(mrdata0), .MemEN(men0), .MemWE(mwe0), .MemAddr(maddr0), .MemWData(mwdata0),
      .RData(rdata0), .Ready(rdy0), .Stall(stall0), .BusErr(berr0)
   );

   // RAM models: cleared by reset, write on an enabled write cycle, combinational read.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (men && mwe) begin
         mem[maddr[9:2]] <= mwdata;
      end
   end
   assign mrdata = mem[maddr[9:2]];

   always @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < 256; j++) mem0[j] <= '0;
      end else if (men0 && mwe0) begin
         mem0[maddr0[9:2]] <= mwdata0;
      end
   end
   assign mrdata0 = mem0[maddr0[9:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Runs one request already driven on the inputs; lat counts edges from accept to Ready.
   task automatic run_acc(input bit on0, input bit mutate, output int lat, output int en_cyc,
                          output int we_cyc, output logic stall_rdy, output logic en_rdy);
      lat = 0;
      en_cyc = 0;
      we_cyc = 0;
      stall_rdy = 1'bx;
      en_rdy = 1'bx;
      @(posedge clk); #1;
      if (mutate) begin
         addr  = 32'h0000_0900;
         wdata = 32'h0;
         cs    = 1'b0;
         we    = 1'b0;
      end
      for (int i = 0; i < 20; i++) begin
         if (on0 ? rdy0 : rdy) begin
            stall_rdy = on0 ? stall0 : stall;
            en_rdy    = on0 ? men0 : men;
            if (on0) req0 = 1'b0;
            else     req  = 1'b0;
            return;
         end
         if (on0 ? men0 : men) en_cyc++;
         if (on0 ? mwe0 : mwe) we_cyc++;
         @(posedge clk); #1;
         lat++;
      end
      lat = -1;
      req = 1'b0;
      req0 = 1'b0;
   endtask

   task automatic drive(input logic [31:0] a, input logic c, input logic w, input logic [31:0] d);
      addr  = a;
      cs    = c;
      we    = w;
      wdata = d;
   endtask

   initial begin
      int   lat, en_c, we_c, en_p, rdy_p;
      logic st_r, en_r;
      logic exp_berr;
`ifdef DMEM_BUS_ERROR_EN
      exp_berr = 1'b1;
`else
      exp_berr = 1'b0;
`endif

      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 32'(rdy), 32'h0);
      chk("rst_men", 32'(men), 32'h0);
      chk("rst_mwe", 32'(mwe), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_maddr", 32'(maddr), 32'h0);
      chk("rst_mwdata", mwdata, 32'h0);
      chk("rst_berr", 32'(berr), 32'h0);
      chk("rst_ready0", 32'(rdy0), 32'h0);

      // Test 1: reset mid-access of a store
      drive(32'h0000_0520, 1'b1, 1'b1, 32'h1111_1111);
      req = 1'b1;
      @(posedge clk); #1;
      chk("t1_men_access", 32'(men), 32'h1);
      chk("t1_maddr", 32'(maddr), 32'h020);
      rst = 1'b1;
      req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("t1_men", 32'(men), 32'h0);
      chk("t1_mwe", 32'(mwe), 32'h0);
      chk("t1_ready", 32'(rdy), 32'h0);
      chk("t1_stall", 32'(stall), 32'h0);
      en_p = 0;
      rdy_p = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (men) en_p++;
         if (rdy) rdy_p++;
      end
      chk("t1_en_after", 32'(en_p), 32'h0);
      chk("t1_rdy_after", 32'(rdy_p), 32'h0);
      chk("t1_mem_unwritten", mem[8], 32'h0);

      // Test 2: store 0xDEADBEEF at 0x0504
      drive(32'h0000_0504, 1'b1, 1'b1, 32'hDEAD_BEEF);
      req = 1'b1;
      #1;
      chk("t2_stall_idle_req", 32'(stall), 32'h1);
      run_acc(1'b0, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t2_latency", 32'(lat), 32'd3);
      chk("t2_we_cycles", 32'(we_c), 32'd3);
      chk("t2_stall_on_ready", 32'(st_r), 32'h0);
      chk("t2_men_on_ready", 32'(en_r), 32'h0);
      chk("t2_maddr", 32'(maddr), 32'h004);
      chk("t2_mwdata", mwdata, 32'hDEAD_BEEF);
      chk("t2_berr", 32'(berr), 32'h0);
      @(posedge clk); #1;
      chk("t2_ready_one_cycle", 32'(rdy), 32'h0);
      chk("t2_mem", mem[1], 32'hDEAD_BEEF);

      // Test 3: load back, then RData holds through a store
      drive(32'h0000_0504, 1'b1, 1'b0, 32'h0);
      req = 1'b1;
      run_acc(1'b0, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t3_latency", 32'(lat), 32'd3);
      chk("t3_en_cycles", 32'(en_c), 32'd3);
      chk("t3_we_cycles", 32'(we_c), 32'd0);
      chk("t3_rdata", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      drive(32'h0000_0508, 1'b1, 1'b1, 32'hCAFE_F00D);
      req = 1'b1;
      run_acc(1'b0, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t3_store_latency", 32'(lat), 32'd3);
      chk("t3_rdata_hold", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("t3_mem2", mem[2], 32'hCAFE_F00D);

      // Test 4: out-of-window request
      drive(32'h0000_04FF, 1'b0, 1'b0, 32'h0);
      req = 1'b1;
      #1;
      chk("t4_stall_idle_req", 32'(stall), 32'h1);
      run_acc(1'b0, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t4_latency", 32'(lat), 32'd0);
      chk("t4_men_on_ready", 32'(en_r), 32'h0);
      chk("t4_berr", 32'(berr), 32'(exp_berr));
      chk("t4_rdata_unchanged", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("t4_berr_clear", 32'(berr), 32'h0);
      chk("t4_men_after", 32'(men), 32'h0);

      // Test 6: input changes during ACCESS are ignored
      drive(32'h0000_050C, 1'b1, 1'b1, 32'h1234_5678);
      req = 1'b1;
      run_acc(1'b0, 1'b1, lat, en_c, we_c, st_r, en_r);
      chk("t6_latency", 32'(lat), 32'd3);
      chk("t6_we_cycles", 32'(we_c), 32'd3);
      chk("t6_maddr", 32'(maddr), 32'h00C);
      chk("t6_mwdata", mwdata, 32'h1234_5678);
      @(posedge clk); #1;
      chk("t6_mem3", mem[3], 32'h1234_5678);
      chk("t6_mem0_untouched", mem[0], 32'h0);

      // Test 5: zero wait states, window edge and back-to-back load
      drive(32'h0000_0500, 1'b1, 1'b1, 32'h5A5A_5A5A);
      req0 = 1'b1;
      run_acc(1'b1, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t5_store0_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      drive(32'h0000_08FF, 1'b1, 1'b1, 32'hA5A5_A5A5);
      req0 = 1'b1;
      run_acc(1'b1, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t5_store1_we_cycles", 32'(we_c), 32'd1);
      @(posedge clk); #1;
      chk("t5_mem0_top", mem0[255], 32'hA5A5_A5A5);
      drive(32'h0000_08FF, 1'b1, 1'b0, 32'h0);
      req0 = 1'b1;
      run_acc(1'b1, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t5_load_latency", 32'(lat), 32'd1);
      chk("t5_maddr_top", 32'(maddr0), 32'h3FF);
      chk("t5_rdata_top", rdata0, 32'hA5A5_A5A5);
      drive(32'h0000_0500, 1'b1, 1'b0, 32'h0);
      req0 = 1'b1;
      @(posedge clk); #1;
      chk("t5_b2b_idle_ready", 32'(rdy0), 32'h0);
      chk("t5_b2b_idle_men", 32'(men0), 32'h0);
      chk("t5_b2b_idle_stall", 32'(stall0), 32'h1);
      run_acc(1'b1, 1'b0, lat, en_c, we_c, st_r, en_r);
      chk("t5_b2b_latency", 32'(lat), 32'd1);
      chk("t5_b2b_maddr", 32'(maddr0), 32'h000);
      chk("t5_b2b_rdata", rdata0, 32'h5A5A_5A5A);
      chk("t5_b2b_stall_on_ready", 32'(st_r), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "time limit");
   end

endmodule
